// File: rtl/mem_wr_pkg.sv
// Shared types and defaults for the burst write sequencer.
// Holds the FSM encoding and the default memory geometry.
package mem_wr_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_wr_csum.sv
// Running XOR of the words written during one burst.
// Cleared on command accept, holds after the burst ends.
module mem_wr_csum
    import mem_wr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] csum
);

    logic [DATA_W-1:0] csum_q;

    // Clear on a new command, fold in each written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (clr) begin
            csum_q <= '0;
        end else if (en) begin
            csum_q <= csum_q ^ data;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/mem_burst_writer.sv
// Burst write sequencer for a 2**ADDR_W x DATA_W single-port memory.
// Define MEM_BURST_WR_CSUM_EN to add the checksum output.
module mem_burst_writer
    import mem_wr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done
`ifdef MEM_BURST_WR_CSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;

    // State, pointer, counter and registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Next state, beat handling and ready/busy decode from state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ptr_d = cmd_base;
                    cnt_d = (cmd_len > DEPTH) ? DEPTH : cmd_len;
                    if (cmd_len == '0) begin
                        // Nothing to commit: report right away.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    wr_en_d = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Pulse once the last strobe's word has been committed.
                done_d  = wr_en_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_enable  = wr_en_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;
    assign done       = done_q;

`ifdef MEM_BURST_WR_CSUM_EN
    logic cmd_acc;
    logic beat;

    assign cmd_acc = (state_q == ST_IDLE) && cmd_valid;
    assign beat    = (state_q == ST_WRITE) && in_valid && !abort;

    mem_wr_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cmd_acc),
        .en    (beat),
        .data  (in_data),
        .csum  (checksum)
    );
`endif

endmodule

// File: tb/tb_mem_burst_writer.sv
// Self-checking bench for mem_burst_writer.
// Burst table plus hand sequences; writes checked via scoreboard.
module tb_mem_burst_writer;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          abort;
    logic          wr_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;
`ifdef MEM_BURST_WR_CSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_burst_writer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .abort      (abort),
        .wr_enable  (wr_enable),
        .write_addr (write_addr),
        .write_data (write_data),
        .busy       (busy),
`ifdef MEM_BURST_WR_CSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int base;
        int len;
        int stall_at;
        int stall_cyc;
        int abort_at;
        int d0;
        int exp_wr;
        int exp_done;
    } vec_t;

    wr_t           sb[$];
    vec_t          vecs[7];
    logic [DW-1:0] mem[32];
    int            checks   = 0;
    int            errors   = 0;
    int            wr_cnt   = 0;
    int            done_cnt = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: commits on the edge after the strobe.
    always @(posedge clk) begin
        if (wr_enable) mem[write_addr] <= write_data;
    end

    // Scoreboard consumer and done counter.
    always @(negedge clk) begin
        if (rst_n && wr_enable) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr", DW'(write_addr), DW'(e.a));
                chk("write_data", write_data, e.d);
            end
        end
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_ready();
        int k;
        k = 0;
        while (!cmd_ready && k < 10) begin
            tick();
            k++;
        end
        chk("cmd_ready_wait", DW'(cmd_ready), 32'd1);
    endtask

    task automatic send_cmd(input int base, input int len);
        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int w0;
        int d0;
        bit aborted;
        n = (v.len > 32) ? 32 : v.len;
        w0 = wr_cnt;
        d0 = done_cnt;
        aborted = 0;
        send_cmd(v.base, v.len);
        if (n == 0) begin
            chk("zero_done", DW'(done), 32'd1);
            chk("zero_no_wr", DW'(wr_enable), 32'd0);
            tick();
            chk("zero_done_end", DW'(done), 32'd0);
            chk("zero_idle", DW'(cmd_ready), 32'd1);
        end else begin
            chk("in_ready", DW'(in_ready), 32'd1);
            for (int i = 0; i < n; i++) begin
                if (i == v.stall_at) begin
                    in_valid = 1'b0;
                    for (int s = 0; s < v.stall_cyc; s++) begin
                        tick();
                        chk("stall_no_wr", DW'(wr_enable), 32'd0);
                    end
                end
                if (i == v.abort_at) begin
                    in_valid = 1'b1;
                    abort    = 1'b1;
                    in_data  = 32'hDEAD_BEEF;
                    tick();
                    in_valid = 1'b0;
                    abort    = 1'b0;
                    chk("abort_no_wr", DW'(wr_enable), 32'd0);
                    chk("abort_cmd_ready", DW'(cmd_ready), 32'd1);
                    chk("abort_busy", DW'(busy), 32'd0);
                    aborted = 1;
                    break;
                end
                in_valid = 1'b1;
                in_data  = DW'(v.d0 + i);
                sb.push_back('{a: AW'(v.base + i), d: DW'(v.d0 + i)});
                tick();
                chk("beat_wr", DW'(wr_enable), 32'd1);
            end
            in_valid = 1'b0;
            if (!aborted) begin
                chk("last_no_done", DW'(done), 32'd0);
                chk("done_state_cmd_ready", DW'(cmd_ready), 32'd0);
                tick();
                chk("done_pulse", DW'(done), 32'd1);
                chk("done_no_wr", DW'(wr_enable), 32'd0);
                tick();
                chk("done_end", DW'(done), 32'd0);
                chk("readback", mem[AW'(v.base)], DW'(v.d0));
            end else begin
                tick();
                tick();
            end
        end
        chk("sb_empty", DW'(sb.size()), 32'd0);
        chk("write_count", DW'(wr_cnt - w0), DW'(v.exp_wr));
        chk("done_count", DW'(done_cnt - d0), DW'(v.exp_done));
    endtask

    initial begin
        int d0;
        vecs[0] = '{10, 3, -1, 0, -1, 20, 3, 1};
        vecs[1] = '{30, 4, -1, 0, -1, 1, 4, 1};
        vecs[2] = '{0, 5, 2, 3, -1, 100, 5, 1};
        vecs[3] = '{5, 5, -1, 0, 2, 200, 2, 0};
        vecs[4] = '{7, 0, -1, 0, -1, 0, 0, 1};
        vecs[5] = '{3, 40, -1, 0, -1, 300, 32, 1};
        vecs[6] = '{31, 1, -1, 0, -1, 77, 1, 1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", DW'(cmd_ready), 32'd1);
        chk("rst_in_ready", DW'(in_ready), 32'd0);
        chk("rst_wr", DW'(wr_enable), 32'd0);
        chk("rst_addr", DW'(write_addr), 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("rst_done", DW'(done), 32'd0);
        chk("rst_busy", DW'(busy), 32'd0);
`ifdef MEM_BURST_WR_CSUM_EN
        chk("rst_csum", checksum, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_cmd_ready", DW'(cmd_ready), 32'd1);
            chk("idle_wr", DW'(wr_enable), 32'd0);
            chk("idle_done", DW'(done), 32'd0);
        end

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted mid-burst.
        d0 = done_cnt;
        send_cmd(4, 8);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(500 + i);
            sb.push_back('{a: AW'(4 + i), d: DW'(500 + i)});
            tick();
        end
        chk("pre_rst_wr", DW'(wr_enable), 32'd1);
        chk("pre_rst_busy", DW'(busy), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_wr", DW'(wr_enable), 32'd0);
        chk("async_rst_busy", DW'(busy), 32'd0);
        chk("async_rst_cmd_ready", DW'(cmd_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_done", DW'(done_cnt - d0), 32'd0);
        chk("post_rst_idle", DW'(cmd_ready), 32'd1);

`ifdef MEM_BURST_WR_CSUM_EN
        begin
            logic [DW-1:0] cdat[3];
            cdat[0] = 32'hF0;
            cdat[1] = 32'h0F;
            cdat[2] = 32'hFF;
            send_cmd(12, 3);
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_data  = cdat[i];
                sb.push_back('{a: AW'(12 + i), d: cdat[i]});
                tick();
                if (i == 0) chk("csum_first", checksum, 32'hF0);
            end
            in_valid = 1'b0;
            tick();
            tick();
            chk("csum_final", checksum, 32'h00);
            send_cmd(20, 1);
            in_valid = 1'b1;
            in_data  = 32'hA5;
            sb.push_back('{a: AW'(20), d: 32'hA5});
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            chk("csum_hold", checksum, 32'hA5);
            send_cmd(0, 0);
            chk("csum_clear", checksum, 32'h00);
            tick();
        end
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_writer.md
# mem_burst_writer

Upstream write-side sequencer for the 32-entry × 32-bit single-port memory (`single_memo`). It accepts a burst command (base address and length) and then a stream of data words over a valid/ready handshake. It drives the memory's `wr_enable`, `write_addr` and `write_data` directly, one word per cycle, with address wrap-around. It signals completion with a one-cycle `done` pulse so a downstream reader knows the region is valid.

## Interface

Parameters:
- `ADDR_W`, 5: memory address width; depth is 2**ADDR_W.
- `DATA_W`, 32: memory word width.

Ports:
- `clk`, input, 1: single clock; rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `cmd_valid`, input, 1: burst command offered.
- `cmd_ready`, output, 1: block can accept a command.
- `cmd_base`, input, ADDR_W: first write address.
- `cmd_len`, input, ADDR_W+1: number of words to write.
- `in_valid`, input, 1: data word offered.
- `in_ready`, output, 1: block accepts the data word.
- `in_data`, input, DATA_W: data word.
- `abort`, input, 1: cancel the burst in progress.
- `wr_enable`, output, 1: memory write strobe.
- `write_addr`, output, ADDR_W: memory write address.
- `write_data`, output, DATA_W: memory write data.
- `busy`, output, 1: a burst is in progress.
- `done`, output, 1: one-cycle pulse when a burst completes.
- `checksum`, output, DATA_W: running XOR of the burst's written words. Present only when the configuration macro is defined.

## Operation

The block is a three-state FSM: IDLE, WRITE, DONE.

- **IDLE**
  - `cmd_ready` = 1.
  - When `cmd_valid` is high, latch `cmd_base` into the address pointer and `cmd_len` into the remaining-word counter.
  - If `cmd_len` == 0, go to DONE. Otherwise go to WRITE.
  - A `cmd_len` greater than 2**ADDR_W saturates to 2**ADDR_W.
- **WRITE**
  - `in_ready` = 1 and `busy` = 1.
  - Each `in_valid` && `in_ready` cycle is a beat. A beat registers `wr_enable`=1, `write_addr`=pointer and `write_data`=`in_data`, then increments the pointer and decrements the counter.
  - The pointer wraps modulo 2**ADDR_W; for example, base 30 with length 4 writes addresses 30, 31, 0, 1.
  - A beat that takes the counter to 0 moves the FSM to DONE.
  - `abort` high goes to IDLE with no `done`. If a beat coincides with `abort`, `abort` wins and that beat is not written.
- **DONE**
  - `done` = 1 for exactly one cycle; `busy` = 0.
  - Next state is IDLE unconditionally.
  - A new command is not accepted during DONE.
- Ready signals:
  - `cmd_ready` and `in_ready` are decoded combinationally from state only. They never depend on `cmd_valid` or `in_valid`.
  - `in_ready` = 0 outside WRITE.
- Data stalls: `in_valid` low in WRITE holds state and counter, and drives `wr_enable` low the next cycle.

## Timing

- Reset values: the FSM is in IDLE.
  - `wr_enable`=0, `write_addr`=0, `write_data`=0.
  - `done`=0, `busy`=0, `in_ready`=0, `cmd_ready`=1.
  - `checksum`=0.
- Reset mid-burst clears every register asynchronously. `wr_enable` drops without waiting for a clock edge, and no partial `done` is produced.
- Write latency: a beat accepted on edge N appears on `wr_enable`/`write_addr`/`write_data` after edge N. The memory commits the word on edge N+1.
- `done` is asserted in the cycle after the last beat's write strobe, so that memory word is already committed when `done` is high.
- Zero-length command:
  - Cycle after acceptance: `done`=1.
  - Next cycle: back in IDLE.
- Back-to-back bursts:
  - Minimum command-to-command spacing is length+2 cycles.
  - Full-rate streaming gives one write per cycle with no bubbles.

## Configuration

- `MEM_BURST_WR_CSUM_EN` defined:
  - The `checksum` port exists.
  - It is cleared when a command is accepted and XORs in each written word on its beat edge.
  - It holds its value through DONE and IDLE until the next command.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure

- Shared package `mem_wr_pkg` holds:
  - the FSM state enum (IDLE, WRITE, DONE);
  - the default `ADDR_W`/`DATA_W` values;
  - `MEM_DEPTH` = 2**ADDR_W.
- One natural sub-module: `mem_wr_csum`, the XOR accumulator. It is instantiated only under `MEM_BURST_WR_CSUM_EN`.

## Test plan

- **Reset/idle:** hold `rst_n`=0, then release with no command. Expect `cmd_ready`=1, `wr_enable`=0 and `done`=0 throughout.
- **Basic burst:** base=10, len=3, data 20, 21, 22 streamed at full rate.
  - Expect writes to 10/11/12 on consecutive cycles.
  - Expect `done` one cycle after the last strobe.
  - A read of address 10 returns 20.
- **Wrap-around:** base=30, len=4, data 1..4. Expect addresses 30, 31, 0, 1.
- **Stall and abort:**
  - len=5 with `in_valid` low for 3 cycles after the 2nd beat: no strobes during the gap, and the remaining beats go to the next addresses.
  - A separate burst with `abort` on the 3rd beat: only 2 writes, no `done`, `cmd_ready` high the following cycle.
- **Edge lengths:**
  - len=0: `done` one cycle after acceptance, with no writes.
  - len=40: saturates to 32 writes.
  - `rst_n` pulsed low mid-burst: `wr_enable` drops immediately and the FSM returns to IDLE.
- **Checksum (with `MEM_BURST_WR_CSUM_EN`):** data 0xF0, 0x0F, 0xFF gives `checksum`=0x00. It is cleared on the next command.
